// File: rtl/vid_param_cap.sv
// Video timing parameter capture: measures active width, active line count and
// total line length each frame, commits them on vsync when the frame is consistent.
module vid_param_cap #(
  parameter int PARAM_WIDTH = 16
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTN,
  input  logic                   i_vsync_sync,
  input  logic                   i_hsync_sync,
  input  logic                   i_den_sync,
  input  logic                   i_weight_wr_mode,
  input  logic                   i_mirror_mode,
  input  logic                   i_blur_mode,
  output logic                   o_weight_wr_mode_cap,
  output logic                   o_mirror_mode_cap,
  output logic                   o_blur_mode_cap,
  output logic [PARAM_WIDTH-1:0] o_hact_cap,
  output logic [PARAM_WIDTH-1:0] o_vact_cap,
  output logic [PARAM_WIDTH-1:0] o_htotal,
  output logic                   o_param_valid,
  output logic                   o_fmt_err
);

  localparam logic [PARAM_WIDTH-1:0] CNT_ZERO = {PARAM_WIDTH{1'b0}};
  localparam logic [PARAM_WIDTH-1:0] CNT_ONE  = {{(PARAM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PARAM_WIDTH-1:0] CNT_MAX  = {PARAM_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [PARAM_WIDTH-1:0] sat_inc(input logic [PARAM_WIDTH-1:0] val);
    if (val == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = val + CNT_ONE;
    end
  endfunction

  state_t                 state_r;
  logic                   vsync_dly_r;
  logic                   hsync_dly_r;
  logic                   den_dly_r;
  logic [PARAM_WIDTH-1:0] hcnt_r;
  logic [PARAM_WIDTH-1:0] lcnt_r;
  logic [PARAM_WIDTH-1:0] tcnt_r;
  logic [PARAM_WIDTH-1:0] ref_hact_r;
  logic [PARAM_WIDTH-1:0] meas_htotal_r;
  logic                   have_ref_r;
  logic                   mismatch_r;
  logic                   skip_line_r;

  logic                   vs_edge_s;
  logic                   hs_edge_s;
  logic                   den_rise_s;
  logic                   den_fall_s;
  logic                   line_done_s;
  logic                   eff_have_ref_s;
  logic [PARAM_WIDTH-1:0] eff_ref_hact_s;
  logic [PARAM_WIDTH-1:0] eff_htotal_s;
  logic                   eff_mismatch_s;
  logic                   sat_hit_s;
  logic                   commit_ok_s;

  assign vs_edge_s  = i_vsync_sync & ~vsync_dly_r;
  assign hs_edge_s  = i_hsync_sync & ~hsync_dly_r;
  assign den_rise_s = i_den_sync & ~den_dly_r;
  assign den_fall_s = ~i_den_sync & den_dly_r;

  // Measurement state including this cycle's line end / hsync, so a commit on
  // vsync sees a line or hsync that lands on the same edge.
  always_comb begin
    eff_have_ref_s = have_ref_r;
    eff_ref_hact_s = ref_hact_r;
    eff_mismatch_s = mismatch_r;
    line_done_s    = den_fall_s & ~skip_line_r;
    if (line_done_s && have_ref_r) begin
      if (hcnt_r != ref_hact_r) begin
        eff_mismatch_s = 1'b1;
      end else begin
        eff_mismatch_s = mismatch_r;
      end
    end else if (line_done_s) begin
      eff_have_ref_s = 1'b1;
      eff_ref_hact_s = hcnt_r;
    end else begin
      eff_have_ref_s = have_ref_r;
    end
    if (hs_edge_s) begin
      eff_htotal_s = sat_inc(tcnt_r);
    end else begin
      eff_htotal_s = meas_htotal_r;
    end
  end

  assign sat_hit_s = (i_den_sync & ~skip_line_r & (hcnt_r == CNT_MAX)) |
                     (den_rise_s & (lcnt_r == CNT_MAX)) |
                     (tcnt_r == CNT_MAX);

  // A frame whose only line never finished has no reference width and is rejected.
  assign commit_ok_s = (lcnt_r != CNT_ZERO) & eff_have_ref_s & ~eff_mismatch_s &
                       ~(hs_edge_s & (tcnt_r == CNT_MAX));

  // Edge-detect delays and per-frame measurement counters.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      vsync_dly_r   <= 1'b0;
      hsync_dly_r   <= 1'b0;
      den_dly_r     <= 1'b0;
      hcnt_r        <= CNT_ZERO;
      lcnt_r        <= CNT_ZERO;
      tcnt_r        <= CNT_ZERO;
      ref_hact_r    <= CNT_ZERO;
      meas_htotal_r <= CNT_ZERO;
      have_ref_r    <= 1'b0;
      mismatch_r    <= 1'b0;
      skip_line_r   <= 1'b0;
    end else begin
      vsync_dly_r <= i_vsync_sync;
      hsync_dly_r <= i_hsync_sync;
      den_dly_r   <= i_den_sync;
      if (vs_edge_s) begin
        // A line already active at frame start is partial and gets ignored.
        if (den_rise_s) begin
          hcnt_r <= CNT_ONE;
          lcnt_r <= CNT_ONE;
        end else begin
          hcnt_r <= CNT_ZERO;
          lcnt_r <= CNT_ZERO;
        end
        skip_line_r   <= i_den_sync & den_dly_r;
        tcnt_r        <= CNT_ZERO;
        meas_htotal_r <= CNT_ZERO;
        ref_hact_r    <= CNT_ZERO;
        have_ref_r    <= 1'b0;
        mismatch_r    <= 1'b0;
      end else begin
        if (den_fall_s) begin
          hcnt_r      <= CNT_ZERO;
          skip_line_r <= 1'b0;
        end else if (i_den_sync) begin
          hcnt_r <= sat_inc(hcnt_r);
        end else begin
          hcnt_r <= hcnt_r;
        end
        if (den_rise_s) begin
          lcnt_r <= sat_inc(lcnt_r);
        end else begin
          lcnt_r <= lcnt_r;
        end
        if (hs_edge_s) begin
          tcnt_r <= CNT_ZERO;
        end else begin
          tcnt_r <= sat_inc(tcnt_r);
        end
        meas_htotal_r <= eff_htotal_s;
        ref_hact_r    <= eff_ref_hact_s;
        have_ref_r    <= eff_have_ref_s;
        mismatch_r    <= eff_mismatch_s | sat_hit_s;
      end
    end
  end

  // Frame FSM with registered parameter, mode and error outputs.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_r              <= WAIT_VS;
      o_weight_wr_mode_cap <= 1'b0;
      o_mirror_mode_cap    <= 1'b0;
      o_blur_mode_cap      <= 1'b0;
      o_hact_cap           <= CNT_ZERO;
      o_vact_cap           <= CNT_ZERO;
      o_htotal             <= CNT_ZERO;
      o_param_valid        <= 1'b0;
      o_fmt_err            <= 1'b0;
    end else begin
      o_fmt_err <= 1'b0;
      if (vs_edge_s) begin
        o_weight_wr_mode_cap <= i_weight_wr_mode;
        o_mirror_mode_cap    <= i_mirror_mode;
        o_blur_mode_cap      <= i_blur_mode;
      end
      case (state_r)
        WAIT_VS: begin
          if (vs_edge_s) begin
            state_r <= MEASURE;
          end else begin
            state_r <= WAIT_VS;
          end
        end
        MEASURE, LOCKED: begin
          if (vs_edge_s) begin
            if (commit_ok_s) begin
              o_hact_cap    <= eff_ref_hact_s;
              o_vact_cap    <= lcnt_r;
              o_htotal      <= eff_htotal_s;
              o_param_valid <= 1'b1;
              state_r       <= LOCKED;
            end else begin
              o_param_valid <= 1'b0;
              o_fmt_err     <= 1'b1;
              state_r       <= MEASURE;
            end
          end
        end
        default: begin
          state_r <= WAIT_VS;
        end
      endcase
    end
  end

endmodule
